popcount_accum: RTL

- Parametrised, pipelined successor to the fixed 5-input combinational bit-sum.
- Counts the set bits of a WIDTH-bit vector through a two-stage valid/ready pipeline.
- Emits a per-vector count and keeps a saturating running total of all delivered counts.
- Sits between a bit-vector producer and a statistics consumer; full backpressure throughout.

---
 rtl/popcount_accum.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/popcount_accum.sv
// Two-stage valid/ready popcount pipeline with a saturating running total of delivered counts.
// Define POPCOUNT_ACCUM_MAX_EN to add the max_count output (running maximum of delivered counts).
module popcount_accum #(
    parameter int WIDTH = 5,
    parameter int ACC_W = 16,
    localparam int CNT_W = $clog2(WIDTH + 1),
    localparam int LO_W  = WIDTH / 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic [ACC_W-1:0] acc_total,
    output logic             acc_sat
`ifdef POPCOUNT_ACCUM_MAX_EN
    ,
    output logic [CNT_W-1:0] max_count
`endif
);

    localparam logic [WIDTH-1:0] LO_MASK = {{(WIDTH - LO_W){1'b0}}, {LO_W{1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

    function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = {CNT_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + {{(CNT_W - 1){1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    logic             a_valid_q, a_valid_d;
    logic [CNT_W-1:0] lo_sum_q, lo_sum_d;
    logic [CNT_W-1:0] hi_sum_q, hi_sum_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic [ACC_W-1:0] acc_total_q, acc_total_d;
    logic             acc_sat_q, acc_sat_d;
    logic [ACC_W-1:0] acc_base_s;
    logic             sat_base_s;
    logic [ACC_W:0]   acc_sum_s;
    logic             b_ready_s;
    logic             accept_s;
    logic             fire_s;

    assign b_ready_s = !out_valid_q || out_ready;
    assign in_ready  = !a_valid_q || b_ready_s;
    assign accept_s  = in_valid && in_ready;
    assign fire_s    = out_valid_q && out_ready;

    // Stage A: partial sums load only on acceptance so idle in_data never propagates.
    always_comb begin
        a_valid_d = a_valid_q;
        lo_sum_d  = lo_sum_q;
        hi_sum_d  = hi_sum_q;
        if (accept_s) begin
            a_valid_d = 1'b1;
            lo_sum_d  = popcount(in_data & LO_MASK);
            hi_sum_d  = popcount(in_data & ~LO_MASK);
        end else if (b_ready_s) begin
            a_valid_d = 1'b0;
        end else begin
            a_valid_d = a_valid_q;
        end
    end

    // Stage B: combine halves; the result is bounded by WIDTH so it fits CNT_W exactly.
    always_comb begin
        out_valid_d = out_valid_q;
        out_count_d = out_count_q;
        if (a_valid_q && b_ready_s) begin
            out_valid_d = 1'b1;
            out_count_d = lo_sum_q + hi_sum_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Accumulator: clear is applied before a coincident fire adds its count.
    always_comb begin
        acc_base_s  = acc_total_q;
        sat_base_s  = acc_sat_q;
        acc_total_d = acc_total_q;
        acc_sat_d   = acc_sat_q;
        if (clear) begin
            acc_base_s = {ACC_W{1'b0}};
            sat_base_s = 1'b0;
        end else begin
            acc_base_s = acc_total_q;
            sat_base_s = acc_sat_q;
        end
        acc_sum_s = {1'b0, acc_base_s} + {{(ACC_W + 1 - CNT_W){1'b0}}, out_count_q};
        if (fire_s) begin
            if (acc_sum_s[ACC_W]) begin
                acc_total_d = ACC_MAX;
                acc_sat_d   = 1'b1;
            end else begin
                acc_total_d = acc_sum_s[ACC_W-1:0];
                acc_sat_d   = sat_base_s;
            end
        end else begin
            acc_total_d = acc_base_s;
            acc_sat_d   = sat_base_s;
        end
    end

    // Pipeline and accumulator state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_valid_q   <= 1'b0;
            lo_sum_q    <= {CNT_W{1'b0}};
            hi_sum_q    <= {CNT_W{1'b0}};
            out_valid_q <= 1'b0;
            out_count_q <= {CNT_W{1'b0}};
            acc_total_q <= {ACC_W{1'b0}};
            acc_sat_q   <= 1'b0;
        end else begin
            a_valid_q   <= a_valid_d;
            lo_sum_q    <= lo_sum_d;
            hi_sum_q    <= hi_sum_d;
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
            acc_total_q <= acc_total_d;
            acc_sat_q   <= acc_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_count = out_count_q;
    assign acc_total = acc_total_q;
    assign acc_sat   = acc_sat_q;

`ifdef POPCOUNT_ACCUM_MAX_EN
    logic [CNT_W-1:0] max_count_q, max_count_d;
    logic [CNT_W-1:0] max_base_s;

    // Running maximum, sharing the clear-then-update ordering of the accumulator.
    always_comb begin
        max_base_s  = max_count_q;
        max_count_d = max_count_q;
        if (clear) begin
            max_base_s = {CNT_W{1'b0}};
        end else begin
            max_base_s = max_count_q;
        end
        if (fire_s && (out_count_q > max_base_s)) begin
            max_count_d = out_count_q;
        end else begin
            max_count_d = max_base_s;
        end
    end

    // Running maximum register.
    always_ff @(posedge clk) begin
        if (reset) begin
            max_count_q <= {CNT_W{1'b0}};
        end else begin
            max_count_q <= max_count_d;
        end
    end

    assign max_count = max_count_q;
`endif

endmodule
